// File: rtl/ibex_lsm_mask_ctrl.sv
// ibex_lsm_mask_ctrl
//   Load-store-mask controller for the secure load/store path. It owns the
//   four LSMSEED CSRs (12'h800..12'h803). On a mask request it steps the
//   selected seed through a Galois LFSR NumSteps times. It then presents
//   the result to the LSU with a valid/ack handshake.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   csr_we_i          CSR write strobe
//   csr_addr_i        CSR address
//   csr_wdata_i       CSR write data
//   csr_hit_o         address is one of the LSMSEED CSRs (combinational)
//   csr_rdata_o       selected seed on a hit, else 0 (combinational)
//   mask_req_i        mask request from the secure LSU
//   mask_seed_sel_i   seed index for the request
//   mask_gnt_o        request accepted (combinational, IDLE only)
//   mask_valid_o      mask_o holds a fresh mask
//   mask_o            generated mask
//   mask_ack_i        LSU consumed the mask
//   flush_i           abort the in-flight request
module ibex_lsm_mask_ctrl #(
    parameter int unsigned NumSteps   = 2,
    parameter logic [31:0] LfsrPoly   = 32'hB400_0000,
    parameter logic [31:0] SeedRstVal = 32'h1F2E_3D4C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_hit_o,
    output logic [31:0] csr_rdata_o,
    input  logic        mask_req_i,
    input  logic [1:0]  mask_seed_sel_i,
    output logic        mask_gnt_o,
    output logic        mask_valid_o,
    output logic [31:0] mask_o,
    input  logic        mask_ack_i,
    input  logic        flush_i
);

    if ((NumSteps < 1) || (NumSteps > 15)) begin : g_bad_num_steps
        $error("ibex_lsm_mask_ctrl: NumSteps must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        VALID
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] seed_q [4];
    logic [3:0]  cnt_q;
    logic [1:0]  sel_q;
    logic [31:0] mask_q;

    logic        csr_wr;
    logic [31:0] wdata_nz;
    logic [31:0] step_val;
    logic        collide;
    logic [31:0] gen_val;
    logic        last_step;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LfsrPoly : '0);
    endfunction

    assign csr_hit_o   = (csr_addr_i[11:2] == 10'h200);
    assign csr_rdata_o = csr_hit_o ? seed_q[csr_addr_i[1:0]] : '0;
    assign csr_wr      = csr_we_i & csr_hit_o;
    // An all-zero seed would lock the LFSR, so zero is stored as one.
    assign wdata_nz    = (csr_wdata_i == '0) ? 32'h0000_0001 : csr_wdata_i;

    assign step_val  = lfsr_step(seed_q[sel_q]);
    // A CSR write to the seed being stepped wins over the step that cycle.
    assign collide   = csr_wr && (csr_addr_i[1:0] == sel_q) && (state_q == GEN);
    assign gen_val   = collide ? wdata_nz : step_val;
    assign last_step = (state_q == GEN) && (cnt_q == '0);

    assign mask_valid_o = (state_q == VALID);
    assign mask_o       = mask_q;

    always_comb begin
        state_d    = state_q;
        mask_gnt_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mask_req_i && !flush_i) begin
                    mask_gnt_o = 1'b1;
                    state_d    = GEN;
                end
            end
            GEN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (flush_i || mask_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            mask_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                seed_q[i] <= SeedRstVal ^ 32'(i);
            end
        end else begin
            state_q <= state_d;

            if (mask_gnt_o) begin
                sel_q <= mask_seed_sel_i;
                cnt_q <= 4'(NumSteps - 1);
            end else if ((state_q == GEN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Steps are committed to the seed even if the request is later flushed.
            for (int unsigned i = 0; i < 4; i++) begin
                if (csr_wr && (csr_addr_i[1:0] == 2'(i))) begin
                    seed_q[i] <= wdata_nz;
                end else if ((state_q == GEN) && (sel_q == 2'(i))) begin
                    seed_q[i] <= step_val;
                end
            end

            if (last_step && !flush_i) begin
                mask_q <= gen_val;
            end
        end
    end

endmodule

// File: tb/tb_ibex_lsm_mask_ctrl.sv
module tb_ibex_lsm_mask_ctrl;

    localparam int unsigned NS   = 2;
    localparam logic [31:0] POLY = 32'hB400_0000;
    localparam logic [31:0] RSTV = 32'h1F2E_3D4C;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    logic        mask_req;
    logic [1:0]  mask_seed_sel;
    logic        mask_gnt;
    logic        mask_valid;
    logic [31:0] mask;
    logic        mask_ack;
    logic        flush;

    ibex_lsm_mask_ctrl #(
        .NumSteps  (NS),
        .LfsrPoly  (POLY),
        .SeedRstVal(RSTV)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .csr_we_i       (csr_we),
        .csr_addr_i     (csr_addr),
        .csr_wdata_i    (csr_wdata),
        .csr_hit_o      (csr_hit),
        .csr_rdata_o    (csr_rdata),
        .mask_req_i     (mask_req),
        .mask_seed_sel_i(mask_seed_sel),
        .mask_gnt_o     (mask_gnt),
        .mask_valid_o   (mask_valid),
        .mask_o         (mask),
        .mask_ack_i     (mask_ack),
        .flush_i        (flush)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [31:0] m_seed [4];
    logic [31:0] exp_q [$];
    logic [31:0] last_mask;

    function automatic logic [31:0] lfsr(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    function automatic logic [31:0] nz(input logic [31:0] v);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic bit is_hit(input logic [11:0] a);
        return (a >= 12'h800) && (a <= 12'h803);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected mask whenever the DUT raises valid, checks hold while valid.
    logic        mon_pv = 1'b0;
    logic [31:0] mon_held;
    always @(negedge clk) begin
        if (mask_valid && !mon_pv) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("mask", mask, exp_q.pop_front());
            end
            mon_held = mask;
        end else if (mask_valid && mon_pv) begin
            chk("mask_hold", mask, mon_held);
        end
        mon_pv = mask_valid;
    end

    task automatic defaults();
        rst       = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
        mask_req  = 1'b0;
        mask_seed_sel = 2'd0;
        mask_ack  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_seed[i] = RSTV ^ 32'(i);
        last_mask = 32'h0;
        exp_q.delete();
    endtask

    task automatic csr_read(input logic [11:0] a);
        @(negedge clk);
        defaults();
        csr_addr = a;
        #1;
        chk("csr_hit", 32'(csr_hit), 32'(is_hit(a)));
        chk("csr_rdata", csr_rdata, is_hit(a) ? m_seed[a[1:0]] : 32'h0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        defaults();
        csr_we = 1'b1;
        csr_addr = a;
        csr_wdata = d;
        if (is_hit(a)) m_seed[a[1:0]] = nz(d);
    endtask

    // One request. flush_at / wr_at are GEN cycle indices (-1 = none).
    task automatic txn(input logic [1:0] sel, input int flush_at, input int wr_at,
                       input logic [11:0] wa, input logic [31:0] wd,
                       input int ack_dly, input bit flush_valid, input bit hold);
        logic [31:0] s;
        bit flushed;
        @(negedge clk);
        defaults();
        mask_req = 1'b1;
        mask_seed_sel = sel;
        #1;
        chk("idle_valid", 32'(mask_valid), 32'd0);
        chk("mask_kept", mask, last_mask);
        chk("gnt_idle", 32'(mask_gnt), 32'd1);

        // Expected outcome: NumSteps LFSR steps on the seed, a colliding write replaces one.
        s = m_seed[sel];
        flushed = 1'b0;
        for (int k = 0; k < int'(NS); k++) begin
            if (k == wr_at && is_hit(wa)) begin
                if (wa[1:0] == sel) s = nz(wd);
                else begin
                    m_seed[wa[1:0]] = nz(wd);
                    s = lfsr(s);
                end
            end else begin
                s = lfsr(s);
            end
            if (k == flush_at) begin
                flushed = 1'b1;
                break;
            end
        end
        m_seed[sel] = s;
        if (!flushed) begin
            exp_q.push_back(s);
            last_mask = s;
        end

        for (int k = 0; k < int'(NS); k++) begin
            @(negedge clk);
            defaults();
            mask_req = hold;
            mask_seed_sel = sel;
            if (k == wr_at) begin
                csr_we = 1'b1;
                csr_addr = wa;
                csr_wdata = wd;
            end
            flush = (k == flush_at);
            #1;
            chk("gnt_gen", 32'(mask_gnt), 32'd0);
            chk("valid_gen", 32'(mask_valid), 32'd0);
            if (k == flush_at) return;
        end

        for (int i = 0; i <= ack_dly; i++) begin
            @(negedge clk);
            defaults();
            mask_req = hold;
            mask_seed_sel = sel;
            mask_ack = (i == ack_dly);
            flush = (i == ack_dly) && flush_valid;
            #1;
            chk("valid_lat", 32'(mask_valid), 32'd1);
            chk("gnt_valid", 32'(mask_gnt), 32'd0);
        end
    endtask

    initial begin
        defaults();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(mask_valid), 32'd0);
        chk("rst_mask", mask, 32'h0);

        // CSR reset values and address decode
        csr_read(12'h800);
        chk("seed0_const", csr_rdata, 32'h1F2E_3D4C);
        csr_read(12'h803);
        chk("seed3_const", csr_rdata, 32'h1F2E_3D4F);
        csr_read(12'h804);
        csr_read(12'h7FF);

        // Basic mask generation and ack
        csr_write(12'h800, 32'h1);
        txn(2'd0, -1, -1, 12'h0, 32'h0, 1, 1'b0, 1'b0);
        chk("mask_5a", last_mask, 32'h5A00_0000);
        csr_read(12'h800);
        chk("seed0_5a", csr_rdata, 32'h5A00_0000);

        // Zero write substitution
        csr_write(12'h802, 32'h0);
        csr_read(12'h802);
        chk("zero_subst", csr_rdata, 32'h1);

        // Flush on the first GEN cycle, then immediate new grant
        txn(2'd1, 0, -1, 12'h0, 32'h0, 0, 1'b0, 1'b0);
        txn(2'd2, -1, -1, 12'h0, 32'h0, 0, 1'b0, 1'b0);
        csr_read(12'h801);
        chk("seed1_flush", csr_rdata, 32'hBB97_1EA6);

        // Request held high across two back-to-back masks
        csr_write(12'h800, 32'h1);
        txn(2'd0, -1, -1, 12'h0, 32'h0, 2, 1'b0, 1'b1);
        chk("hold_m1", last_mask, 32'h5A00_0000);
        txn(2'd0, -1, -1, 12'h0, 32'h0, 0, 1'b0, 1'b1);
        chk("hold_m2", last_mask, 32'h1680_0000);

        // CSR write collides with the final GEN step
        csr_write(12'h800, 32'h1);
        txn(2'd0, -1, int'(NS) - 1, 12'h800, 32'h8, 0, 1'b0, 1'b0);
        csr_read(12'h800);
        chk("collide_seed", csr_rdata, 32'h8);
        chk("collide_mask", last_mask, 32'h8);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  sel;
            int          fa, wa_i, dly;
            logic [11:0] wa;
            logic [31:0] wd;
            sel  = 2'($urandom_range(0, 3));
            fa   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
            wa_i = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
            wa   = ($urandom_range(0, 4) == 0) ? 12'h804 : (12'h800 + 12'($urandom_range(0, 3)));
            wd   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            dly  = int'($urandom_range(0, 3));
            txn(sel, fa, wa_i, wa, wd, dly, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) csr_read(12'h800 + 12'($urandom_range(0, 4)));
        end

        // Reset in the middle of GEN restores everything
        @(negedge clk);
        defaults();
        mask_req = 1'b1;
        mask_seed_sel = 2'd3;
        @(negedge clk);
        defaults();
        rst = 1'b1;
        @(negedge clk);
        defaults();
        model_reset();
        #1;
        chk("midrst_valid", 32'(mask_valid), 32'd0);
        chk("midrst_mask", mask, 32'h0);
        for (int i = 0; i < 4; i++) csr_read(12'h800 + 12'(i));

        repeat (3) @(negedge clk);
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ibex_lsm_mask_ctrl.md
Name: ibex_lsm_mask_ctrl

Overview:
Controller for the load-store-mask (LSM) seeds used by the eliminate secure load/store instructions (OPCODE_SEC_LDST).
- Owns the four LSMSEED CSRs at 12'h800..12'h803 and serves CSR reads and writes to them.
- On a mask request from the secure LSU path, steps the selected seed through a Galois LFSR for a fixed number of cycles.
- Hands the resulting 32-bit mask to the LSU with a valid/ack handshake.
- Sits beside ibex_cs_registers and the load-store unit.

Parameters:
NumSteps, 2, LFSR steps per mask request (1..15).
LfsrPoly, 32'hB400_0000, Galois feedback constant.
SeedRstVal, 32'h1F2E_3D4C, base reset value; seed[i] resets to SeedRstVal ^ i.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
csr_we_i  in  1  CSR write strobe
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write data
csr_hit_o  out  1  csr_addr_i is in 12'h800..12'h803 (combinational)
csr_rdata_o  out  32  seed[csr_addr_i[1:0]] when hit, else 0 (combinational)
mask_req_i  in  1  secure LSU requests a mask
mask_seed_sel_i  in  2  seed index for the request
mask_gnt_o  out  1  request accepted (combinational, IDLE only)
mask_valid_o  out  1  mask_o valid
mask_o  out  32  generated mask
mask_ack_i  in  1  LSU consumed the mask
flush_i  in  1  abort the in-flight request (pipeline flush/exception)

Behaviour:
- One clock (clk_i), synchronous active-high reset (rst_i), sampled on the rising edge.
- Reset values: state=IDLE, seed[i]=SeedRstVal^i, mask_o=0, mask_valid_o=0, step counter=0, captured sel=0.
- LFSR step: next = (s>>1) ^ (s[0] ? LfsrPoly : 0).
- States:
  - IDLE: mask_gnt_o = mask_req_i & ~flush_i. On a grant, capture mask_seed_sel_i, load counter with NumSteps-1, go to GEN.
  - GEN: step seed[sel] every cycle. When counter==0, perform the final step, register the stepped value into mask_o and go to VALID. Otherwise decrement the counter.
  - VALID: mask_valid_o=1 and mask_o is held stable. mask_ack_i returns to IDLE.
- Latency: grant at cycle T; GEN occupies T+1..T+NumSteps; mask_valid_o rises at T+NumSteps+1.
- mask_gnt_o is low in GEN and VALID. A request in the same cycle as an ack is not granted; it is granted the next cycle.
- mask_o keeps its last value after ack; only the IDLE->VALID path via GEN updates it.
- Seed steps are committed permanently: mask values are never reused.
- CSR writes:
  - A write to a hit address updates seed[csr_addr_i[1:0]] in any state.
  - A wdata of 0 is stored as 32'h0000_0001 (avoids LFSR lockup).
  - In GEN, a write to the seed being stepped takes priority over the step that cycle. Stepping resumes from the written value next cycle. The counter still decrements.
  - If that collision cycle is the final GEN cycle, mask_o captures the written (zero-substituted) value.
  - Writes to non-hit addresses are ignored.
- flush_i:
  - In GEN or VALID, the next state is IDLE and mask_valid_o drops the next cycle.
  - Steps already applied to the seed are kept.
  - flush_i in IDLE blocks the grant.
  - flush_i has priority over mask_ack_i and over the GEN->VALID transition.
- rst_i asserted mid-operation: all state returns to reset values on the next edge, including the seeds.
- NumSteps outside 1..15 is an elaboration error.

Test Plan:
1. Reset, then read 12'h800 and 12'h803 -> csr_hit_o=1, rdata 32'h1F2E_3D4C and 32'h1F2E_3D4F. Read 12'h804 -> hit=0, rdata=0.
2. Write 32'h1 to 12'h800, then req with sel=0 at T -> gnt=1 at T; valid at T+3 with mask_o=32'h5A00_0000; read 12'h800 returns 32'h5A00_0000. Ack -> valid=0 next cycle; mask_o stays 32'h5A00_0000.
3. Write 32'h0 to 12'h802 -> read returns 32'h0000_0001.
4. Req with sel=1, then flush_i on the first GEN cycle -> state IDLE, valid never asserts. Seed1 equals one LFSR step of 32'h1F2E_3D4D (32'hBB97_1EA6). A new request is granted the cycle after the flush.
5. Hold mask_req_i continuously from the first grant -> second gnt asserts only the cycle after the ack, never during GEN or VALID. Two masks from the same seed differ (32'h5A00_0000, then 32'h1680_0000).
6. Seed0=1, req sel=0, and write 32'h8 to 12'h800 on the second (final) GEN cycle -> mask_o=32'h0000_0008, seed0 reads 32'h0000_0008.
